// File: rtl/stack_mem_responder.sv
// Stack memory responder: serves PUSH/POP/CALL/RET on a live-tracked word RAM.
// Ports: clk, rst (async low), req_* in, rsp_* out, live_cnt = live entry count.
module stack_mem_responder #(
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   live_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [AW:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [AW:0]       lcnt_q, lcnt_d;
  logic              ram_we;
  logic              op_wr, op_rd, bad_addr;

  logic [31:0] ram [DEPTH];

  assign op_wr    = (req_op == OP_PUSH) || (req_op == OP_CALL);
  assign op_rd    = (req_op == OP_POP) || (req_op == OP_RET);
  assign bad_addr = req_addr >= 32'(DEPTH);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    live_d  = live_q;
    lcnt_d  = lcnt_q;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          if (!(op_wr || op_rd) || bad_addr) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = op_rd ? 3'(RD_LAT) : 3'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (op_q == OP_PUSH || op_q == OP_CALL) begin
          ram_we = 1'b1;
          if (!live_q[addr_q]) begin
            live_d[addr_q] = 1'b1;
            lcnt_d = lcnt_q + CNT_ONE;
          end
          state_d = RESP;
        end else if (cnt_q == 3'd1) begin
          // counter expiry edge: capture or flag stale slot
          if (live_q[addr_q]) begin
            rdata_d = ram[addr_q];
            live_d[addr_q] = 1'b0;
            lcnt_d = lcnt_q - CNT_ONE;
            err_d  = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      live_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      live_q  <= live_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // RAM needs no reset: every entry is unreadable until marked live
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr_q] <= wdata_q;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign live_cnt  = lcnt_q;

endmodule
